// File: rtl/ram_fifo_pkg.sv
// Shared defaults and types for the RAM-backed streaming FIFO controller.
package ram_fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 4;
  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned FIFO_CNT_W  = FIFO_ADDR_W + 2;

  typedef enum logic [1:0] {
    PORT_IDLE  = 2'd0,
    PORT_WRITE = 2'd1,
    PORT_READ  = 2'd2
  } port_op_e;

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry in-order output buffer: absorbs RAM read data and presents the head word.
module ram_fifo_obuf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        ob_cnt,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              head_q, head_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tail;
  logic              do_pop;

  // Tail sits one past the head when a single entry is held, on the head otherwise.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail    = head_q ^ cnt_q[0];
    do_pop  = pop & valid_q;
    if (push) mem_d[tail] = push_data;
    if (do_pop) head_d = ~head_q;
    cnt_d   = cnt_q + 2'(push) - 2'(do_pop);
    valid_d = (cnt_d != 2'd0);
    data_d  = mem_d[head_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= 1'b0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ob_cnt  = cnt_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sharing one single-port RAM between stream writes and reads.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W,
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              empty,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned RCNT_W = ADDR_W + 1;
  localparam int unsigned CNT_W  = ADDR_W + 2;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [RCNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic [1:0]        ob_cnt;
  logic              ob_pop;
  logic              rd_elig;
  logic              rd_urgent;
  logic              s_hs;
  port_op_e          op;

  assign ob_pop = m_valid & m_ready;

  // Port arbitration: a starving output buffer beats writes, writes beat refills.
  always_comb begin
    rd_elig   = (ram_cnt_q != '0) &&
                ((3'(ob_cnt) + 3'(inflight_q)) < (3'd2 + 3'(ob_pop)));
    rd_urgent = rd_elig && (ob_cnt == 2'd0) && !inflight_q;
    op        = PORT_IDLE;
    if (!rst) begin
      if (rd_urgent)                op = PORT_READ;
      else if (s_valid && !full_q)  op = PORT_WRITE;
      else if (rd_elig)             op = PORT_READ;
    end
  end

  assign s_ready  = !rst && !full_q && !rd_urgent;
  assign s_hs     = s_valid & s_ready;
  assign ram_we   = (op == PORT_WRITE);
  assign ram_addr = (op == PORT_WRITE) ? wr_ptr_q : (rst ? '0 : rd_ptr_q);
  assign ram_din  = (op == PORT_WRITE) ? s_data : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = 1'b0;
    case (op)
      PORT_WRITE: begin
        wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
        ram_cnt_d = ram_cnt_q + RCNT_W'(1);
      end
      PORT_READ: begin
        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
        ram_cnt_d  = ram_cnt_q - RCNT_W'(1);
        inflight_d = 1'b1;
      end
      default: ;
    endcase
    count_d = count_q + CNT_W'(s_hs) - CNT_W'(ob_pop);
    full_d  = (ram_cnt_d == RCNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  // Read data returns one edge after issue; a read cut off by reset is dropped.
  ram_fifo_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (ram_dout),
    .pop       (ob_pop),
    .ob_cnt    (ob_cnt),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule
